// File: rtl/uart_cfg_if.sv
// Host-side byte port of uart_cfg: TX push, RX pop and line status.
interface uart_cfg_if;
  logic       wr_uart;
  logic [7:0] data_in;
  logic       tx_full;
  logic       rd_uart;
  logic [7:0] data_out;
  logic       rx_empty;
  logic [7:0] data_LSR;

  modport master (output wr_uart, data_in, rd_uart,
                  input  tx_full, data_out, rx_empty, data_LSR);
  modport slave  (input  wr_uart, data_in, rd_uart,
                  output tx_full, data_out, rx_empty, data_LSR);
endinterface

// File: rtl/uart_cfg.sv
// Configurable UART with per-direction FIFOs and a sticky line status register.
// Parity generation/checking is compiled in only when UART_PARITY_EN is defined.
module uart_cfg #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic      clock,
  input  logic      reset,
  input  logic      rx,
  output logic      tx,
  uart_cfg_if.slave bus
);
  localparam int unsigned DIV      = CLK_FREQ / (BAUD * 16);
  localparam int unsigned DivW     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);
  localparam int unsigned AW       = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  DataMask = 8'((1 << DATA_BITS) - 1);
  localparam logic [2:0]  LastData = 3'(DATA_BITS - 1);
  localparam logic [2:0]  LastStop = 3'(STOP_BITS - 1);
  localparam int unsigned RxAlign  = 8 - DATA_BITS;

  // Empty marker block: elaborates only for out-of-range parameter sets.
  if (DATA_BITS < 5 || DATA_BITS > 8 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2 ||
      FIFO_DEPTH < 2) begin : g_illegal_cfg
  end

  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData,
`ifdef UART_PARITY_EN
    TxParity,
`endif
    TxStop
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData,
`ifdef UART_PARITY_EN
    RxParity,
`endif
    RxStop, RxBreak
  } rx_state_e;

  logic [DivW-1:0] r_div_cnt;
  logic            w_tick;
  assign w_tick = (r_div_cnt == DivLast);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       r_div_cnt <= '0;
    else if (w_tick) r_div_cnt <= '0;
    else             r_div_cnt <= r_div_cnt + 1'b1;
  end

  // TX FIFO; the extra pointer bit separates full from empty.
  logic [7:0] r_txf_mem [FIFO_DEPTH];
  logic [AW:0] r_txf_wp, r_txf_rp;
  logic w_txf_full, w_txf_empty, w_txf_push, w_txf_pop;
  assign w_txf_empty = (r_txf_wp == r_txf_rp);
  assign w_txf_full  = (r_txf_wp == {~r_txf_rp[AW], r_txf_rp[AW-1:0]});
  assign w_txf_push  = bus.wr_uart && !w_txf_full;

  always_ff @(posedge clock) begin
    if (w_txf_push) r_txf_mem[r_txf_wp[AW-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_txf_wp <= '0;
      r_txf_rp <= '0;
    end else begin
      if (w_txf_push) r_txf_wp <= r_txf_wp + 1'b1;
      if (w_txf_pop)  r_txf_rp <= r_txf_rp + 1'b1;
    end
  end

  tx_state_e  r_tx_state, w_tx_state_d;
  logic [3:0] r_tx_tick, w_tx_tick_d;
  logic [2:0] r_tx_bit, w_tx_bit_d;
  logic [7:0] r_tx_shift, w_tx_shift_d;
  logic       w_tx_load;

  always_comb begin
    w_tx_state_d = r_tx_state;
    w_tx_tick_d  = r_tx_tick;
    w_tx_bit_d   = r_tx_bit;
    w_tx_shift_d = r_tx_shift;
    w_tx_load    = 1'b0;
    w_txf_pop    = 1'b0;
    if (w_tick) begin
      if (r_tx_state == TxIdle) begin
        w_tx_load = !w_txf_empty;
      end else if (r_tx_tick != 4'd15) begin
        w_tx_tick_d = r_tx_tick + 4'd1;
      end else begin
        w_tx_tick_d = 4'd0;
        case (r_tx_state)
          TxStart: begin
            w_tx_state_d = TxData;
            w_tx_bit_d   = 3'd0;
          end
          TxData: begin
            if (r_tx_bit == LastData) begin
              w_tx_bit_d = 3'd0;
`ifdef UART_PARITY_EN
              w_tx_state_d = (PARITY != 0) ? TxParity : TxStop;
`else
              w_tx_state_d = TxStop;
`endif
            end else begin
              w_tx_bit_d   = r_tx_bit + 3'd1;
              w_tx_shift_d = {1'b0, r_tx_shift[7:1]};
            end
          end
`ifdef UART_PARITY_EN
          TxParity: w_tx_state_d = TxStop;
`endif
          TxStop: begin
            if (r_tx_bit != LastStop)  w_tx_bit_d = r_tx_bit + 3'd1;
            else if (!w_txf_empty)     w_tx_load = 1'b1;
            else                       w_tx_state_d = TxIdle;
          end
          default: w_tx_state_d = TxIdle;
        endcase
      end
    end
    // Loading from Idle or straight out of the last stop bit chains frames without a gap.
    if (w_tx_load) begin
      w_txf_pop    = 1'b1;
      w_tx_state_d = TxStart;
      w_tx_tick_d  = 4'd0;
      w_tx_shift_d = r_txf_mem[r_txf_rp[AW-1:0]] & DataMask;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_state <= TxIdle;
      r_tx_tick  <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
    end else begin
      r_tx_state <= w_tx_state_d;
      r_tx_tick  <= w_tx_tick_d;
      r_tx_bit   <= w_tx_bit_d;
      r_tx_shift <= w_tx_shift_d;
    end
  end

`ifdef UART_PARITY_EN
  logic r_tx_par;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_tx_par <= 1'b0;
    else if (w_tx_load) r_tx_par <= (PARITY == 1) ? ~^w_tx_shift_d : ^w_tx_shift_d;
  end
`endif

  always_comb begin
    tx = 1'b1;
    case (r_tx_state)
      TxStart:  tx = 1'b0;
      TxData:   tx = r_tx_shift[0];
`ifdef UART_PARITY_EN
      TxParity: tx = r_tx_par;
`endif
      default:  tx = 1'b1;
    endcase
  end

  logic r_rx_s1, r_rx_s2, r_rx_s3;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  rx_state_e  r_rx_state, w_rx_state_d;
  logic [3:0] r_rx_tick, w_rx_tick_d;
  logic [2:0] r_rx_bit, w_rx_bit_d;
  logic [7:0] r_rx_shift, w_rx_shift_d;
  logic [7:0] w_rx_char;
  logic       w_rx_done, w_rx_break, w_par_ok, w_par_zero;

  assign w_rx_char  = r_rx_shift >> RxAlign;
  assign w_rx_break = w_par_zero && (w_rx_char == 8'd0) && !r_rx_s2;

`ifdef UART_PARITY_EN
  logic r_rx_par, w_rx_par_d;
  assign w_par_ok   = (PARITY == 0) ||
                      (r_rx_par == ((PARITY == 1) ? ~^w_rx_char : ^w_rx_char));
  assign w_par_zero = (PARITY == 0) || !r_rx_par;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_rx_par <= 1'b0;
    else       r_rx_par <= w_rx_par_d;
  end
`else
  assign w_par_ok   = 1'b1;
  assign w_par_zero = 1'b1;
`endif

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_rx_tick_d  = r_rx_tick;
    w_rx_bit_d   = r_rx_bit;
    w_rx_shift_d = r_rx_shift;
    w_rx_done    = 1'b0;
`ifdef UART_PARITY_EN
    w_rx_par_d   = r_rx_par;
`endif
    case (r_rx_state)
      RxIdle: begin
        if (r_rx_s3 && !r_rx_s2) begin
          w_rx_state_d = RxStart;
          w_rx_tick_d  = 4'd0;
        end
      end
      RxStart: begin
        if (w_tick) begin
          if (r_rx_tick == 4'd7) begin
            w_rx_tick_d  = 4'd0;
            w_rx_bit_d   = 3'd0;
            w_rx_state_d = r_rx_s2 ? RxIdle : RxData;
          end else begin
            w_rx_tick_d = r_rx_tick + 4'd1;
          end
        end
      end
      RxBreak: if (r_rx_s2) w_rx_state_d = RxIdle;
      default: begin
        if (w_tick) begin
          if (r_rx_tick != 4'd15) begin
            w_rx_tick_d = r_rx_tick + 4'd1;
          end else begin
            w_rx_tick_d = 4'd0;
            if (r_rx_state == RxData) begin
              w_rx_shift_d = {r_rx_s2, r_rx_shift[7:1]};
              w_rx_bit_d   = r_rx_bit + 3'd1;
              if (r_rx_bit == LastData) begin
`ifdef UART_PARITY_EN
                w_rx_state_d = (PARITY != 0) ? RxParity : RxStop;
`else
                w_rx_state_d = RxStop;
`endif
              end
`ifdef UART_PARITY_EN
            end else if (r_rx_state == RxParity) begin
              w_rx_par_d   = r_rx_s2;
              w_rx_state_d = RxStop;
`endif
            end else begin
              w_rx_done    = 1'b1;
              w_rx_state_d = w_rx_break ? RxBreak : RxIdle;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rx_state <= RxIdle;
      r_rx_tick  <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
    end else begin
      r_rx_state <= w_rx_state_d;
      r_rx_tick  <= w_rx_tick_d;
      r_rx_bit   <= w_rx_bit_d;
      r_rx_shift <= w_rx_shift_d;
    end
  end

  logic [7:0] r_rxf_mem [FIFO_DEPTH];
  logic [AW:0] r_rxf_wp, r_rxf_rp;
  logic w_rxf_full, w_rxf_empty, w_rxf_push, w_rxf_pop, w_overrun;
  assign w_rxf_empty = (r_rxf_wp == r_rxf_rp);
  assign w_rxf_full  = (r_rxf_wp == {~r_rxf_rp[AW], r_rxf_rp[AW-1:0]});
  assign w_rxf_pop   = bus.rd_uart && !w_rxf_empty;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign w_rxf_push  = w_rx_done && (!w_rxf_full || w_rxf_pop);
  assign w_overrun   = w_rx_done && w_rxf_full && !w_rxf_pop;

  always_ff @(posedge clock) begin
    if (w_rxf_push) r_rxf_mem[r_rxf_wp[AW-1:0]] <= w_rx_char;
  end

  logic [7:0] r_data_out;
  logic       r_lsr_oe, r_lsr_pe, r_lsr_fe, r_lsr_bi;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rxf_wp   <= '0;
      r_rxf_rp   <= '0;
      r_data_out <= '0;
      r_lsr_oe   <= 1'b0;
      r_lsr_pe   <= 1'b0;
      r_lsr_fe   <= 1'b0;
      r_lsr_bi   <= 1'b0;
    end else begin
      if (w_rxf_push) r_rxf_wp <= r_rxf_wp + 1'b1;
      if (w_rxf_pop) begin
        r_rxf_rp   <= r_rxf_rp + 1'b1;
        r_data_out <= r_rxf_mem[r_rxf_rp[AW-1:0]];
      end
      r_lsr_oe <= (r_lsr_oe && !w_rxf_pop) || w_overrun;
      r_lsr_pe <= (r_lsr_pe && !w_rxf_pop) || (w_rx_done && !w_par_ok);
      r_lsr_fe <= (r_lsr_fe && !w_rxf_pop) || (w_rx_done && !r_rx_s2);
      r_lsr_bi <= (r_lsr_bi && !w_rxf_pop) || (w_rx_done && w_rx_break);
    end
  end

  assign bus.tx_full  = w_txf_full;
  assign bus.rx_empty = w_rxf_empty;
  assign bus.data_out = r_data_out;
  assign bus.data_LSR = {1'b0, (r_tx_state == TxIdle) && w_txf_empty, w_txf_empty,
                         r_lsr_bi, r_lsr_fe, r_lsr_pe, r_lsr_oe, !w_rxf_empty};
endmodule

// File: tb/tb_uart_cfg.sv
// Directed bench for uart_cfg: loopback vectors, overrun, parity framing, line errors, reset.
module tb_uart_cfg;
  localparam int unsigned BitClks = 64;

  logic clk = 1'b0;
  logic rst;
  logic loop_a;
  logic tb_rx;
  logic tx_a, rx_a, tx_b, rx_b;

  always #5 clk = ~clk;

  uart_cfg_if u_if_a ();
  uart_cfg_if u_if_b ();

  assign rx_a = loop_a ? tx_a : tb_rx;
  assign rx_b = tx_b;

  uart_cfg #(
    .CLK_FREQ(640000), .BAUD(10000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clock(clk), .reset(rst), .rx(rx_a), .tx(tx_a), .bus(u_if_a.slave)
  );

  uart_cfg #(
    .CLK_FREQ(640000), .BAUD(10000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clock(clk), .reset(rst), .rx(rx_b), .tx(tx_b), .bus(u_if_b.slave)
  );

  typedef struct {
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] lsr;
  } lb_vec_t;

  lb_vec_t vecs [4];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h, want 0x%02h", name, act, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] d);
    @(negedge clk);
    u_if_a.wr_uart = 1'b1;
    u_if_a.data_in = d;
    @(negedge clk);
    u_if_a.wr_uart = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    @(negedge clk);
    u_if_b.wr_uart = 1'b1;
    u_if_b.data_in = d;
    @(negedge clk);
    u_if_b.wr_uart = 1'b0;
  endtask

  task automatic read_a();
    @(negedge clk);
    u_if_a.rd_uart = 1'b1;
    @(negedge clk);
    u_if_a.rd_uart = 1'b0;
  endtask

  task automatic read_b();
    @(negedge clk);
    u_if_b.rd_uart = 1'b1;
    @(negedge clk);
    u_if_b.rd_uart = 1'b0;
  endtask

  task automatic wait_ready_a(input string name);
    int n = 0;
    while (u_if_a.rx_empty && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, {7'd0, u_if_a.rx_empty}, 8'h00);
  endtask

  task automatic wait_ready_b(input string name);
    int n = 0;
    while (u_if_b.rx_empty && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check(name, {7'd0, u_if_b.rx_empty}, 8'h00);
  endtask

  task automatic send_rx(input logic [7:0] d, input logic stop);
    tb_rx = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      tb_rx = d[i];
      repeat (BitClks) @(negedge clk);
    end
    tb_rx = stop;
    repeat (BitClks) @(negedge clk);
    tb_rx = 1'b1;
  endtask

  initial begin
    logic [6:0] exp_bits;
    int n;
    vecs[0] = '{din: 8'hA5, dout: 8'hA5, lsr: 8'h61};
    vecs[1] = '{din: 8'h00, dout: 8'h00, lsr: 8'h61};
    vecs[2] = '{din: 8'hFF, dout: 8'hFF, lsr: 8'h61};
    vecs[3] = '{din: 8'h3C, dout: 8'h3C, lsr: 8'h61};

    rst = 1'b1;
    loop_a = 1'b1;
    tb_rx = 1'b1;
    u_if_a.wr_uart = 1'b0; u_if_a.rd_uart = 1'b0; u_if_a.data_in = 8'h00;
    u_if_b.wr_uart = 1'b0; u_if_b.rd_uart = 1'b0; u_if_b.data_in = 8'h00;
    repeat (3) @(negedge clk);
    check("reset tx", {7'd0, tx_a}, 8'h01);
    check("reset tx_full", {7'd0, u_if_a.tx_full}, 8'h00);
    check("reset rx_empty", {7'd0, u_if_a.rx_empty}, 8'h01);
    check("reset data_out", u_if_a.data_out, 8'h00);
    check("reset lsr", u_if_a.data_LSR, 8'h60);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Loopback table: frame completes, status before read, data and status after read.
    for (int i = 0; i < 4; i++) begin
      push_a(vecs[i].din);
      wait_ready_a("loopback ready");
      repeat (BitClks) @(negedge clk);
      check("loopback lsr before read", u_if_a.data_LSR, vecs[i].lsr);
      read_a();
      check("loopback data", u_if_a.data_out, vecs[i].dout);
      check("loopback lsr after read", u_if_a.data_LSR, 8'h60);
    end

    // Five chained frames into a 4-deep RX FIFO: last one overruns.
    for (int i = 1; i <= 4; i++) push_a(8'(i));
    repeat (8) @(negedge clk);
    push_a(8'h05);
    repeat (3600) @(negedge clk);
    check("overrun lsr", u_if_a.data_LSR, 8'h63);
    for (int i = 0; i < 4; i++) begin
      read_a();
      check("overrun read data", u_if_a.data_out, 8'(i + 1));
      check("overrun read lsr", u_if_a.data_LSR, (i == 3) ? 8'h60 : 8'h61);
    end

    // 7-bit even-parity frame of 0xD3: data 1100101 LSB first.
    exp_bits = 7'h53;
    push_b(8'hD3);
    n = 0;
    while (tx_b && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (BitClks / 2) @(negedge clk);
    check("parity start bit", {7'd0, tx_b}, 8'h00);
    for (int i = 0; i < 7; i++) begin
      repeat (BitClks) @(negedge clk);
      check("parity data bit", {7'd0, tx_b}, {7'd0, exp_bits[i]});
    end
    repeat (BitClks) @(negedge clk);
`ifdef UART_PARITY_EN
    check("parity bit", {7'd0, tx_b}, 8'h00);
    repeat (BitClks) @(negedge clk);
`endif
    check("parity stop bit", {7'd0, tx_b}, 8'h01);
    wait_ready_b("parity ready");
    repeat (BitClks) @(negedge clk);
    check("parity lsr before read", u_if_b.data_LSR, 8'h61);
    read_b();
    check("parity data", u_if_b.data_out, 8'h53);
    check("parity lsr after read", u_if_b.data_LSR, 8'h60);

    // Framing error: 0x3C with stop bit 0.
    loop_a = 1'b0;
    repeat (BitClks) @(negedge clk);
    send_rx(8'h3C, 1'b0);
    wait_ready_a("framing ready");
    repeat (BitClks) @(negedge clk);
    check("framing lsr", u_if_a.data_LSR, 8'h69);
    read_a();
    check("framing data", u_if_a.data_out, 8'h3C);
    check("framing lsr after read", u_if_a.data_LSR, 8'h60);

    // Break: line low for two frame times yields exactly one 0x00 character.
    tb_rx = 1'b0;
    repeat (20 * BitClks) @(negedge clk);
    tb_rx = 1'b1;
    repeat (4 * BitClks) @(negedge clk);
    wait_ready_a("break ready");
    check("break lsr", u_if_a.data_LSR, 8'h79);
    read_a();
    check("break data", u_if_a.data_out, 8'h00);
    check("break single push", {7'd0, u_if_a.rx_empty}, 8'h01);
    check("break lsr after read", u_if_a.data_LSR, 8'h60);

    // Reset in the middle of data bit 1 of 0xA5 (a 0 on the line).
    loop_a = 1'b1;
    repeat (BitClks) @(negedge clk);
    push_a(8'hA5);
    n = 0;
    while (tx_a && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (BitClks * 2 + BitClks / 2) @(negedge clk);
    check("mid frame tx low", {7'd0, tx_a}, 8'h00);
    rst = 1'b1;
    #1;
    check("mid reset tx", {7'd0, tx_a}, 8'h01);
    check("mid reset tx_full", {7'd0, u_if_a.tx_full}, 8'h00);
    check("mid reset rx_empty", {7'd0, u_if_a.rx_empty}, 8'h01);
    check("mid reset lsr", u_if_a.data_LSR, 8'h60);
    @(negedge clk);
    rst = 1'b0;
    repeat (16 * BitClks) @(negedge clk);
    check("no spurious byte", {7'd0, u_if_a.rx_empty}, 8'h01);
    check("idle lsr after reset", u_if_a.data_LSR, 8'h60);
    check("idle tx after reset", {7'd0, tx_a}, 8'h01);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_cfg.md
UART_CFG -- requirements
Module: uart_cfg

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 9600, meaning the line rate in bit/s.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning character length; legal values are 5..8.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameters STOP_BITS (default 1, legal 1..2) and FIFO_DEPTH (default 16, power of 2, minimum 2), meaning stop bit count and per-direction FIFO entries.
REQ-006 SHALL have port clock, input, 1 bit, the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-008 SHALL have port rx, input, 1 bit, serial input, asynchronous to clock.
REQ-009 SHALL have port tx, output, 1 bit, serial output; idle level is 1.
REQ-010 SHALL have ports wr_uart (input, 1 bit, push strobe), data_in (input, 8 bits, TX byte) and tx_full (output, 1 bit, TX FIFO full).
REQ-011 SHALL have ports rd_uart (input, 1 bit, pop strobe), data_out (output, 8 bits, RX byte) and rx_empty (output, 1 bit, RX FIFO empty).
REQ-012 SHALL have port data_LSR, output, 8 bits: [0] data ready, [1] overrun, [2] parity error, [3] framing error, [4] break, [5] TX FIFO empty, [6] transmitter idle, [7] 0.

Function
REQ-013 SHALL generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks, truncated (325 at default values); every serial bit lasts exactly 16 ticks.
REQ-014 SHALL, on wr_uart=1 with tx_full=0, push data_in into the TX FIFO; wr_uart with tx_full=1 drops the byte and changes no state.
REQ-015 SHALL run the TX FSM IDLE->START->DATA->PARITY->STOP->IDLE; PARITY is skipped when PARITY=0.
REQ-016 SHALL leave IDLE on the first tick with the TX FIFO non-empty, pop one byte, and send a 0 start bit, then DATA_BITS data bits LSB first, then the optional parity bit, then STOP_BITS 1 bits.
REQ-017 SHALL ignore data_in bits above DATA_BITS-1; the parity bit covers the transmitted data bits only (odd: total ones odd; even: total ones even).
REQ-018 SHALL chain back-to-back frames with no idle bit while the TX FIFO is non-empty.
REQ-019 SHALL pass rx through a 2-flop synchroniser before use.
REQ-020 SHALL, in RX IDLE, start on a synchronised 1->0 transition, recheck rx at tick 8, and return to IDLE (glitch reject) if rx is 1.
REQ-021 SHALL sample data, parity and first stop bit at mid-bit (every 16 ticks after the tick-8 check); only the first stop bit is checked on receive.
REQ-022 SHALL push each completed character (zero-extended to 8 bits) into the RX FIFO at the stop-bit sample clock.
REQ-023 SHALL set a parity error on mismatch, a framing error on stop=0, and break when data, parity and stop are all 0; the byte is still pushed.
REQ-024 SHALL, in the break case, wait for rx=1 before rearming.
REQ-025 SHALL, when a character completes with the RX FIFO full and no same-cycle pop, discard it and set overrun.
REQ-026 SHALL, when a character completes on the same cycle as a pop from a full RX FIFO, perform both operations with no overrun.
REQ-027 SHALL, on rd_uart=1 with rx_empty=0, load the FIFO head into registered data_out at that edge and clear LSR[4:1]; data_out holds otherwise and rd_uart while empty is ignored.
REQ-028 SHALL make LSR[4:1] sticky until cleared by a read; an error occurring on the clearing edge wins (bit stays 1).
REQ-029 SHALL have FIFO pointers wrap modulo FIFO_DEPTH; full and empty SHALL be distinguished by an extra pointer bit.

Reset
REQ-030 SHALL, on reset=1 at any time including mid-frame, immediately force tx=1, tx_full=0, rx_empty=1, data_out=0x00, data_LSR=0x60, both FSMs to IDLE, both FIFOs empty and the divisor counter to 0.
REQ-031 SHALL abandon any partially sent or received frame on reset with no FIFO push.

Configuration
REQ-032 SHALL compile parity generation, checking and the PARITY FSM state only when macro UART_PARITY_EN is defined.
REQ-033 SHALL, without UART_PARITY_EN, behave as PARITY=0 for any PARITY value and tie LSR[2] to 0.

Verification
REQ-034 SHALL cover loopback (tx tied to rx) at default parameters: write 0xA5 -> after 10 bit times rx_empty=0; rd_uart -> data_out=0xA5 and data_LSR=0x61 before the read, 0x60 after.
REQ-035 SHALL cover UART_PARITY_EN, DATA_BITS=7, PARITY=2: write 0xD3 -> tx carries data bits 1100101 then parity 0; loopback read -> 0x53 with LSR[2]=0.
REQ-036 SHALL cover FIFO_DEPTH=4 with 5 loopback bytes 0x01..0x05 and no reads -> LSR[1]=1; subsequent reads return 0x01..0x04 in order, and LSR[1]=0 after the first read.
REQ-037 SHALL cover rx driven with 0x3C and stop bit 0 -> data_out=0x3C with LSR[3]=1; rx held low for 2 frame times -> 0x00 with LSR[4]=1 and a single push.
REQ-038 SHALL cover reset asserted mid DATA state -> tx=1 before the next clock edge, tx_full=0, rx_empty=1, data_LSR=0x60, and no spurious byte after release.
